ins_mem_port_arbiter: RTL and testbench
=======================================

INS_MEM_PORT_ARBITER -- requirements
Module: ins_mem_port_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, 1096, word depth of the attached BRAM; addresses at or above MEM_DEPTH*4 are out of range.
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_i  input  2  per-requester access request; bit 0 is core fetch, bit 1 is loader/debug.
REQ-005 addr_i  input  64  byte addresses; bits [31:0] are requester 0, bits [63:32] are requester 1.
REQ-006 we_i  input  2  per-requester write enable.
REQ-007 be_i  input  8  byte enables; bits [3:0] are requester 0, bits [7:4] are requester 1.
REQ-008 wdata_i  input  64  write data; bits [31:0] are requester 0, bits [63:32] are requester 1.
REQ-009 gnt_o  output  2  one-hot grant, combinational, valid in the request cycle.
REQ-010 rvalid_o  output  2  one-hot response valid, one cycle after grant.
REQ-011 rdata_o  output  32  response data, shared by both requesters, qualified by rvalid_o.
REQ-012 mem_clkb  output  1  BRAM clock, equal to clk.
REQ-013 mem_enb  output  1  BRAM enable.
REQ-014 mem_rstb  output  1  BRAM reset, tied to 0.
REQ-015 mem_web  output  4  BRAM byte write enables.
REQ-016 mem_addrb  output  32  BRAM byte address.
REQ-017 mem_dinb  output  32  BRAM write data.
REQ-018 mem_rstb_busy  input  1  BRAM busy; while high, nothing is granted.
REQ-019 mem_doutb  input  32  BRAM read data, registered, one-cycle latency.

Function
REQ-020 At most one gnt_o bit is high per cycle, and only for a requester whose req_i bit is high.
REQ-021 gnt_o is 0 while mem_rstb_busy=1 or reset=1.
REQ-022 Single request: the requester is granted in the same cycle.
REQ-023 Contention arbitration:
- both requesting: grant the requester not granted most recently (round-robin);
- last-grant pointer updates only on a granted cycle.
REQ-024 Requester i holds req_i, addr, we, be and wdata stable until gnt_o[i]=1; the arbiter does not queue requests.
REQ-025 BRAM drive for a granted cycle: mem_enb=1, mem_addrb=granted addr, mem_dinb=granted wdata, mem_web=be & {4{we}}.
REQ-026 With no grant: mem_enb=0, mem_web=0, mem_addrb=0, mem_dinb=0.
REQ-027 Registered owner and valid flags: rvalid_o[i]=1 exactly in the cycle after gnt_o[i]=1, for reads and writes alike.
REQ-028 rdata_o=mem_doutb when any rvalid_o bit is high, else 0.
REQ-029 Back-to-back grants are allowed every cycle, including alternating owners; responses stay in order.
REQ-030 Out-of-range address: the access is granted but mem_enb=0, and rvalid_o fires with rdata_o=32'h00000013 (NOP).

Reset
REQ-031 On reset=1 at a clock edge:
- rvalid_o=0 and owner=0;
- last-grant pointer=1, so requester 0 wins the first contention.
REQ-032 A grant issued in the cycle before reset asserts produces no rvalid_o.
REQ-033 Combinational outputs reflect the reset state while reset=1.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN controls the contention policy.
- Defined: REQ-023 round-robin applies.
- Undefined: fixed priority, requester 0 always wins contention, and the pointer register is omitted.

Structure
REQ-035 Package ins_mem_arb_pkg holds NUM_REQ=2, ADDR_W=32, DATA_W=32, BE_W=4, NOP_INSTR=32'h00000013 and the owner index typedef.
REQ-036 Sub-module rr_arb2 contains the grant logic and pointer register; ins_mem_port_arbiter contains the muxing and the response pipeline.

Verification
REQ-037 Bench covers the following directed scenarios:
- req_i=01, addr 0x4 holding 0xABCD0001 -> gnt_o=01 same cycle; next cycle rvalid_o=01, rdata_o=0xABCD0001.
- req_i=11 held 4 cycles -> gnt_o sequence 01,10,01,10; rvalid_o follows one cycle later, and rdata for each matches its own address.
- Requester 1 writes be=0011, data 0x12345678 to 0x8 holding 0xFFFFFFFF; requester 0 then reads 0x8 -> rdata_o=0xFFFF5678.
- mem_rstb_busy=1 with req_i=11 for 3 cycles -> gnt_o=00 and mem_enb=0 throughout; after busy drops, requester 0 is granted first.
- Grant in cycle N with reset=1 in cycle N+1 -> rvalid_o=00 at N+1 and N+2.
- Build without ARB_ROUND_ROBIN_EN, req_i=11 held 3 cycles -> gnt_o=01 every cycle.

Source files
------------

// File: rtl/ins_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// ins_mem_arb_pkg
// Purpose : Shared widths, constants and the owner index type for the
//           instruction-memory port arbiter.
// Contents: NUM_REQ, ADDR_W, DATA_W, BE_W, NOP_INSTR, owner_t and
//           owner_to_onehot().
// ---------------------------------------------------------------------------
package ins_mem_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;

    // Returned for out-of-range fetches so the core executes a harmless NOP.
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Index of a requester: 0 = core fetch, 1 = loader/debug.
    typedef logic [$clog2(NUM_REQ)-1:0] owner_t;

    function automatic logic [NUM_REQ-1:0] owner_to_onehot(input owner_t owner);
        return (owner == owner_t'(1)) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ins_mem_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Purpose : Two-requester grant logic. The grant is combinational and valid
//           in the request cycle. Nothing is granted while reset or busy is
//           high.
// Config  : ARB_ROUND_ROBIN_EN defined   -> round-robin on contention, with a
//                                           last-grant pointer register.
//           ARB_ROUND_ROBIN_EN undefined -> fixed priority, requester 0 wins;
//                                           no pointer register and no clock.
// Ports   : clk   - clock (round-robin build only)
//           reset - synchronous active-high reset
//           req   - per-requester request
//           busy  - memory busy; blocks all grants
//           gnt   - one-hot grant
// ---------------------------------------------------------------------------
module rr_arb2
    import ins_mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic               clk,
`endif
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               busy,
    output logic [NUM_REQ-1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Pointing at requester 1 makes requester 0 win the first contention.
            last_grant <= owner_t'(1);
        end else if (|gnt) begin
            last_grant <= owner_t'(gnt[1]);
        end
    end
`endif

    // NOTE: gnt gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = '0;
        if (!reset && !busy) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
`ifdef ARB_ROUND_ROBIN_EN
                    // Grant whichever requester was not served most recently.
                    gnt = (last_grant == owner_t'(1)) ? 2'b01 : 2'b10;
`else
                    gnt = 2'b01;
`endif
                end
                default: gnt = '0;
            endcase
        end
    end

endmodule

// File: rtl/ins_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// ins_mem_port_arbiter
// Purpose : Shares one BRAM port between the core fetch (requester 0) and a
//           loader/debug master (requester 1). Grants are combinational.
//           Responses return one cycle after the grant, in order, on a
//           shared rdata_o bus. Out-of-range accesses are granted but do not
//           enable the BRAM, and they return a NOP instruction.
// Config  : ARB_ROUND_ROBIN_EN selects round-robin or fixed-priority
//           contention handling (see rr_arb2).
// Ports   : clk, reset              - clock, synchronous active-high reset
//           req_i/addr_i/we_i/be_i/wdata_i - packed per-requester requests
//                                    (requester 0 in the low slice)
//           gnt_o                   - one-hot grant, same cycle
//           rvalid_o / rdata_o      - one-hot response valid and shared data
//           mem_*                   - BRAM port B drive; mem_rstb_busy blocks
//                                     grants; mem_doutb has one-cycle latency
// ---------------------------------------------------------------------------
module ins_mem_port_arbiter
    import ins_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
    input  logic [NUM_REQ-1:0]         we_i,
    input  logic [NUM_REQ*BE_W-1:0]    be_i,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       mem_clkb,
    output logic                       mem_enb,
    output logic                       mem_rstb,
    output logic [BE_W-1:0]            mem_web,
    output logic [ADDR_W-1:0]          mem_addrb,
    output logic [DATA_W-1:0]          mem_dinb,
    input  logic                       mem_rstb_busy,
    input  logic [DATA_W-1:0]          mem_doutb
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH * 4);

    logic               granted;
    owner_t             sel;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_be;
    logic               sel_we;
    logic               in_range;

    // Response pipeline: one valid flag, its owner and whether it was out of range.
    logic               valid_q;
    owner_t             owner_q;
    logic               oor_q;
    logic               resp_valid;

    rr_arb2 u_arb (
`ifdef ARB_ROUND_ROBIN_EN
        .clk   (clk),
`endif
        .reset (reset),
        .req   (req_i),
        .busy  (mem_rstb_busy),
        .gnt   (gnt_o)
    );

    assign granted = |gnt_o;
    assign sel     = owner_t'(gnt_o[1]);

    always_comb begin
        sel_addr  = addr_i[ADDR_W-1:0];
        sel_wdata = wdata_i[DATA_W-1:0];
        sel_be    = be_i[BE_W-1:0];
        sel_we    = we_i[0];
        if (sel == owner_t'(1)) begin
            sel_addr  = addr_i[2*ADDR_W-1:ADDR_W];
            sel_wdata = wdata_i[2*DATA_W-1:DATA_W];
            sel_be    = be_i[2*BE_W-1:BE_W];
            sel_we    = we_i[1];
        end
    end

    assign in_range = (sel_addr < ADDR_LIMIT);

    // BRAM drive: idle port presents all zeros.
    always_comb begin
        mem_enb   = 1'b0;
        mem_web   = '0;
        mem_addrb = '0;
        mem_dinb  = '0;
        if (granted) begin
            mem_enb   = in_range;
            mem_web   = sel_be & {BE_W{sel_we}};
            mem_addrb = sel_addr;
            mem_dinb  = sel_wdata;
        end
    end

    assign mem_clkb = clk;
    assign mem_rstb = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            owner_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            valid_q <= granted;
            owner_q <= sel;
            oor_q   <= granted & ~in_range;
        end
    end

    // Masking with reset drops a response whose grant landed just before
    // reset, and keeps outputs at their reset values while reset is held.
    assign resp_valid = valid_q & ~reset;
    assign rvalid_o   = resp_valid ? owner_to_onehot(owner_q) : '0;
    assign rdata_o    = !resp_valid ? '0 :
                        oor_q       ? NOP_INSTR : mem_doutb;

endmodule

// File: tb/tb_ins_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ins_mem_port_arbiter
// Directed bench for ins_mem_port_arbiter with a small registered-read BRAM
// model. Inputs change on the falling edge; combinational outputs are
// sampled 1 ns later and registered outputs just after the next falling edge.
// ---------------------------------------------------------------------------
module tb_ins_mem_port_arbiter;

    localparam int unsigned MEM_DEPTH = 1096;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_i;
    logic [63:0] addr_i;
    logic [1:0]  we_i;
    logic [7:0]  be_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        mem_clkb;
    logic        mem_enb;
    logic        mem_rstb;
    logic [3:0]  mem_web;
    logic [31:0] mem_addrb;
    logic [31:0] mem_dinb;
    logic        mem_rstb_busy;
    logic [31:0] mem_doutb;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ins_mem_port_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .wdata_i       (wdata_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .mem_clkb      (mem_clkb),
        .mem_enb       (mem_enb),
        .mem_rstb      (mem_rstb),
        .mem_web       (mem_web),
        .mem_addrb     (mem_addrb),
        .mem_dinb      (mem_dinb),
        .mem_rstb_busy (mem_rstb_busy),
        .mem_doutb     (mem_doutb)
    );

    // BRAM model: read-first, registered output, byte write enables.
    logic [31:0] mem [0:2047];

    always @(posedge mem_clkb) begin
        if (mem_enb) begin
            mem_doutb <= mem[mem_addrb[12:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_web[b]) mem[mem_addrb[12:2]][8*b +: 8] <= mem_dinb[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    logic [1:0] exp_gnt [4];
    logic [1:0] exp_last;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[1]    = 32'hABCD_0001;
        mem[2]    = 32'hFFFF_FFFF;
        mem[4]    = 32'h1111_0004;
        mem[5]    = 32'h2222_0005;
        mem[1095] = 32'h5A5A_0F0F;
        mem_doutb = 32'h0;

`ifdef ARB_ROUND_ROBIN_EN
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        reset = 1'b1; req_i = '0; addr_i = '0; we_i = '0; be_i = '0;
        wdata_i = '0; mem_rstb_busy = 1'b0;

        // Reset held: requests are ignored and outputs sit at reset values.
        @(negedge clk);
        req_i = 2'b11;
        #1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_enb", 32'(mem_enb), 32'h0);
        check("rst_rstb", 32'(mem_rstb), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        @(negedge clk);
        check("rst_rvalid2", 32'(rvalid_o), 32'h0);

        // Contention for four cycles, each requester reading its own word.
        reset  = 1'b0;
        addr_i = {32'h14, 32'h10};
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont_gnt%0d", i), 32'(gnt_o), 32'(exp_gnt[i]));
            check($sformatf("cont_addr%0d", i), mem_addrb, (exp_gnt[i] == 2'b01) ? 32'h10 : 32'h14);
            @(negedge clk);
            check($sformatf("cont_rvalid%0d", i), 32'(rvalid_o), 32'(exp_gnt[i]));
            check($sformatf("cont_rdata%0d", i), rdata_o,
                  (exp_gnt[i] == 2'b01) ? 32'h1111_0004 : 32'h2222_0005);
        end
        exp_last = exp_gnt[3];

        // Busy blocks every grant; requester 0 is first once it drops.
        mem_rstb_busy = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            check($sformatf("busy_gnt%0d", j), 32'(gnt_o), 32'h0);
            check($sformatf("busy_enb%0d", j), 32'(mem_enb), 32'h0);
            @(negedge clk);
            check($sformatf("busy_rvalid%0d", j), 32'(rvalid_o), 32'h0);
        end
        mem_rstb_busy = 1'b0;
        #1;
        check("unbusy_gnt", 32'(gnt_o), 32'h1);
        @(negedge clk);
        check("unbusy_rdata", rdata_o, 32'h1111_0004);

        // Single read by requester 0.
        req_i  = 2'b01;
        addr_i = {32'h0, 32'h4};
        #1;
        check("rd_gnt", 32'(gnt_o), 32'h1);
        check("rd_enb", 32'(mem_enb), 32'h1);
        check("rd_addr", mem_addrb, 32'h4);
        check("rd_web", 32'(mem_web), 32'h0);
        @(negedge clk);
        check("rd_rvalid", 32'(rvalid_o), 32'h1);
        check("rd_rdata", rdata_o, 32'hABCD_0001);

        // Requester 1 partial write, then requester 0 reads it back.
        req_i   = 2'b10;
        addr_i  = {32'h8, 32'h0};
        we_i    = 2'b10;
        be_i    = 8'h30;
        wdata_i = {32'h1234_5678, 32'h0};
        #1;
        check("wr_gnt", 32'(gnt_o), 32'h2);
        check("wr_web", 32'(mem_web), 32'h3);
        check("wr_addr", mem_addrb, 32'h8);
        check("wr_din", mem_dinb, 32'h1234_5678);
        @(negedge clk);
        check("wr_rvalid", 32'(rvalid_o), 32'h2);
        req_i   = 2'b01;
        addr_i  = {32'h0, 32'h8};
        we_i    = 2'b00;
        be_i    = 8'h00;
        wdata_i = '0;
        #1;
        check("rb_gnt", 32'(gnt_o), 32'h1);
        @(negedge clk);
        check("rb_rvalid", 32'(rvalid_o), 32'h1);
        check("rb_rdata", rdata_o, 32'hFFFF_5678);

        // Last in-range word, then the first out-of-range address.
        addr_i = {32'h0, 32'h111C};
        #1;
        check("edge_enb", 32'(mem_enb), 32'h1);
        @(negedge clk);
        check("edge_rdata", rdata_o, 32'h5A5A_0F0F);
        addr_i = {32'h0, 32'h1120};
        #1;
        check("oor_gnt", 32'(gnt_o), 32'h1);
        check("oor_enb", 32'(mem_enb), 32'h0);
        @(negedge clk);
        check("oor_rvalid", 32'(rvalid_o), 32'h1);
        check("oor_rdata", rdata_o, 32'h0000_0013);

        // Idle port drives zeros and no response follows.
        req_i = 2'b00;
        #1;
        check("idle_gnt", 32'(gnt_o), 32'h0);
        check("idle_addr", mem_addrb, 32'h0);
        @(negedge clk);
        check("idle_rvalid", 32'(rvalid_o), 32'h0);
        check("idle_rdata", rdata_o, 32'h0);

        // Grant in cycle N, reset in N+1: no response at N+1 or N+2.
        req_i  = 2'b01;
        addr_i = {32'h0, 32'h4};
        #1;
        check("rstmid_gnt", 32'(gnt_o), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        req_i = 2'b00;
        #1;
        check("rstmid_rvalid1", 32'(rvalid_o), 32'h0);
        check("rstmid_rdata1", rdata_o, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_rvalid2", 32'(rvalid_o), 32'h0);

        // After reset requester 0 wins the first contention in either build.
        @(negedge clk);
        req_i  = 2'b11;
        addr_i = {32'h14, 32'h10};
        #1;
        check("post_rst_gnt", 32'(gnt_o), 32'h1);
        @(negedge clk);
        req_i = 2'b10;
        #1;
        check("solo1_gnt", 32'(gnt_o), 32'h2);
        @(negedge clk);
        check("solo1_rvalid", 32'(rvalid_o), 32'h2);
        check("solo1_rdata", rdata_o, 32'h2222_0005);
        check("last_cont_owner_was_1", 32'(exp_last == 2'b10 || exp_gnt[1] == 2'b01), 32'h1);
        req_i = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
